ps2_kb_ctrl: RTL

PS2_KB_CTRL -- requirements
Module: ps2_kb_ctrl

---
 rtl/ps2_kb_ctrl.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/ps2_kb_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// ps2_kb_ctrl : PS/2 keyboard receiver with scan-code FIFO and CPU read port
// Revision    : 1.0
// ============================================================================
module ps2_kb_ctrl #(
    parameter int SAMPLE_DLY = 8,
    parameter int TIMEOUT    = 4095,
    parameter int DEPTH      = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       KB_CLK,
    input  logic       KB_DATA,
    input  logic       CS,
    input  logic       RD,
    input  logic       ADDR0,
    output logic [7:0] DOUT,
    output logic       IRQ
);

    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(SAMPLE_DLY + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] SMP_LAST = SW'(SAMPLE_DLY);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    logic          kbc_s1_q, kbc_s1_d, kbc_s2_q, kbc_s2_d, kbc_prev_q, kbc_prev_d;
    logic          kbd_s1_q, kbd_s1_d, kbd_s2_q, kbd_s2_d;
    logic          pend_q, pend_d;
    logic [SW-1:0] smp_cnt_q, smp_cnt_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [1:0]    state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          ovr_q, ovr_d, perr_q, perr_d, ferr_q, ferr_d;
    logic          acc_q, acc_d, acc_adr_q, acc_adr_d;
    logic [7:0]    mem_q [DEPTH];

    logic          fall, smp_take, timeout, push_req, set_perr, set_ferr, set_ovr;
    logic          empty, full, bus_act, acc_end, pop, clr, wr_en, good_par;
    logic [7:0]    status, head;

    always_comb begin
        kbc_s1_d   = KB_CLK;
        kbc_s2_d   = kbc_s1_q;
        kbc_prev_d = kbc_s2_q;
        kbd_s1_d   = KB_DATA;
        kbd_s2_d   = kbd_s1_q;
        fall       = kbc_prev_q & ~kbc_s2_q;

        // A sample is armed by each fall and abandoned if KB_CLK rises first
        pend_d    = pend_q;
        smp_cnt_d = smp_cnt_q;
        smp_take  = 1'b0;
        if (fall) begin
            pend_d    = 1'b1;
            smp_cnt_d = SW'(1);
        end else if (pend_q) begin
            if (kbc_s2_q) begin
                pend_d    = 1'b0;
                smp_cnt_d = '0;
            end else if (smp_cnt_q == SMP_LAST) begin
                smp_take  = 1'b1;
                pend_d    = 1'b0;
                smp_cnt_d = '0;
            end else begin
                smp_cnt_d = smp_cnt_q + SW'(1);
            end
        end

        timeout  = 1'b0;
        to_cnt_d = to_cnt_q;
        if (state_q == ST_IDLE || fall) begin
            to_cnt_d = '0;
        end else if (to_cnt_q == TO_LAST) begin
            timeout  = 1'b1;
            to_cnt_d = '0;
        end else begin
            to_cnt_d = to_cnt_q + TW'(1);
        end

        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        push_req  = 1'b0;
        set_perr  = 1'b0;
        set_ferr  = 1'b0;
        good_par  = ^{shift_q, par_q};
        if (timeout) begin
            state_d   = ST_IDLE;
            set_ferr  = 1'b1;
            pend_d    = 1'b0;
            smp_cnt_d = '0;
        end else if (smp_take) begin
            case (state_q)
                ST_IDLE: begin
                    if (!kbd_s2_q) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = 3'd0;
                    end
                end
                ST_DATA: begin
                    shift_d = {kbd_s2_q, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
                    else bit_cnt_d = bit_cnt_q + 3'd1;
                end
                ST_PARITY: begin
                    par_d   = kbd_s2_q;
                    state_d = ST_STOP;
                end
                ST_STOP: begin
                    push_req = kbd_s2_q & good_par;
                    set_perr = ~good_par;
                    set_ferr = ~kbd_s2_q;
                    state_d  = ST_IDLE;
                end
            endcase
        end

        empty     = (count_q == '0);
        full      = (count_q == CNT_FULL);
        bus_act   = CS & RD;
        acc_d     = bus_act;
        acc_adr_d = bus_act ? ADDR0 : acc_adr_q;
        acc_end   = acc_q & ~bus_act;
        pop       = acc_end & ~acc_adr_q & ~empty;
        clr       = acc_end & acc_adr_q;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts
        wr_en     = push_req & (~full | pop);
        set_ovr   = push_req & full & ~pop;

        wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (wr_en && !pop) count_d = count_q + (AW+1)'(1);
        else if (pop && !wr_en) count_d = count_q - (AW+1)'(1);

        ovr_d  = (ovr_q  & ~clr) | set_ovr;
        perr_d = (perr_q & ~clr) | set_perr;
        ferr_d = (ferr_q & ~clr) | set_ferr;

        status = {2'b00, (state_q != ST_IDLE), ferr_q, perr_q, ovr_q, full, ~empty};
        head   = empty ? 8'h00 : mem_q[rd_ptr_q];
        DOUT   = 8'h00;
        if (bus_act) DOUT = ADDR0 ? status : head;
        IRQ    = ~empty;
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            kbc_s1_q   <= 1'b1;
            kbc_s2_q   <= 1'b1;
            kbc_prev_q <= 1'b1;
            kbd_s1_q   <= 1'b1;
            kbd_s2_q   <= 1'b1;
            pend_q     <= 1'b0;
            smp_cnt_q  <= '0;
            to_cnt_q   <= '0;
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'h00;
            par_q      <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            ovr_q      <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            acc_q      <= 1'b0;
            acc_adr_q  <= 1'b0;
        end else begin
            kbc_s1_q   <= kbc_s1_d;
            kbc_s2_q   <= kbc_s2_d;
            kbc_prev_q <= kbc_prev_d;
            kbd_s1_q   <= kbd_s1_d;
            kbd_s2_q   <= kbd_s2_d;
            pend_q     <= pend_d;
            smp_cnt_q  <= smp_cnt_d;
            to_cnt_q   <= to_cnt_d;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            ovr_q      <= ovr_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            acc_q      <= acc_d;
            acc_adr_q  <= acc_adr_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST && wr_en) mem_q[wr_ptr_q] <= shift_q;
    end

endmodule
`default_nettype wire
